// File: rtl/uart_rx_fifo_if.sv
// MMIO bus bundle between the CPU (master) and the uart_rx_fifo peripheral (slave).
interface uart_rx_fifo_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rx_sel;
    logic        rx_ready;
    logic [31:0] rx_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  rx_sel, rx_ready, rx_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output rx_sel, rx_ready, rx_rdata
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 serial receiver with a DEPTH-entry FIFO drained over MMIO, RTS hysteresis flow control.
// Define UART_RX_PARITY_EN for 8E1 frames with parity-error detection (perr).
module uart_rx_fifo #(
    parameter logic [31:0] ADDR  = 32'h4000_2000,
    parameter int          DIV   = 104,
    parameter int          DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus,
    input  logic          ser_rx,
    output logic          ser_rts
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BIT_T  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_T = CW'(DIV / 2 - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_HI   = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]   CNT_LO   = (AW+1)'(DEPTH - 4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n;
    logic          s1, rxd;
    logic          push, ferr_set, perr_set;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic          empty, full;
    logic          ovr, ferr, perr, held;
    logic          is_wr, acc, pop, flush, push_ok, ovr_set;
    logic [1:0]    off;
    logic [2:0]    clr;
    logic [4:0]    cnt5;
    logic [31:0]   rd_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b1;
            rxd <= 1'b1;
        end else begin
            s1  <= ser_rx;
            rxd <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            par     <= par_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        bit_n    = bit_idx;
        sh_n     = sh;
        par_n    = par;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd) state_n = START;
            end
            START: if (cnt == HALF_T) begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = rxd ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_T) begin
                cnt_n = '0;
                sh_n  = {rxd, sh[7:1]};
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
            PARITY: if (cnt == BIT_T) begin
                cnt_n   = '0;
                par_n   = rxd;
                state_n = STOP;
            end
            STOP: if (cnt == BIT_T) begin
                cnt_n = '0;
                // framing error outranks parity error; line must return high before rearming
                if (!rxd) begin
                    ferr_set = 1'b1;
                    state_n  = WAIT_HIGH;
                end else begin
                    state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (^{sh, par}) perr_set = 1'b1;
                    else            push     = 1'b1;
`else
                    push = 1'b1;
`endif
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxd) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign cnt5  = 5'(count);

    assign off   = bus.mem_addr[3:2];
    assign is_wr = |bus.mem_wstrb;
    assign bus.rx_sel = bus.mem_valid && (bus.mem_addr[31:4] == ADDR[31:4]);
    // one access per request: held blocks re-acking while mem_valid lingers after the ack
    assign acc     = bus.rx_sel && !bus.rx_ready && !held;
    assign pop     = acc && !is_wr && (off == 2'd0) && !empty;
    assign flush   = acc && is_wr && (off == 2'd2);
    assign clr     = (acc && is_wr && (off == 2'd1)) ? bus.mem_wdata[2:0] : 3'b000;
    assign push_ok = push && !flush && (!full || pop);
    assign ovr_set = push && !flush && full && !pop;

    always_comb begin
        rd_val = '0;
        if (!is_wr) begin
            case (off)
                2'd0: if (!empty) rd_val = {1'b1, 23'b0, mem[rd_ptr[AW-1:0]]};
                2'd1: rd_val = {16'b0, 3'b0, cnt5, 5'b0, perr, ferr, ovr};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rx_ready <= 1'b0;
            bus.rx_rdata <= '0;
            held         <= 1'b0;
        end else begin
            bus.rx_ready <= acc;
            bus.rx_rdata <= acc ? rd_val : '0;
            held         <= bus.rx_sel && (held || bus.rx_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr     <= 1'b0;
            ferr    <= 1'b0;
            perr    <= 1'b0;
            ser_rts <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~clr[0]);
            ferr <= ferr_set | (ferr & ~clr[1]);
`ifdef UART_RX_PARITY_EN
            perr <= perr_set | (perr & ~clr[2]);
`else
            perr <= 1'b0;
`endif
            if (count >= CNT_HI)      ser_rts <= 1'b1;
            else if (count <= CNT_LO) ser_rts <= 1'b0;
        end
    end

    logic unused;
`ifdef UART_RX_PARITY_EN
    assign unused = ^{bus.mem_wdata[31:3], bus.mem_addr[1:0]};
`else
    assign unused = ^{bus.mem_wdata[31:3], bus.mem_addr[1:0], par, perr_set, clr[2]};
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: register-map vector table, directed corner sequences, random traffic vs a queue model.
module tb_uart_rx_fifo;
    localparam int          DIV   = 8;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h4000_2000;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_EDGE = 87;
`else
    localparam int PUSH_EDGE = 79;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ser_rx;
    logic ser_rts;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.ADDR(BASE), .DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ser_rx(ser_rx), .ser_rts(ser_rts)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    bit m_ovr, m_ferr, m_perr, m_rts;

    typedef struct {
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void upd_rts();
        if (q.size() >= DEPTH - 2)      m_rts = 1'b1;
        else if (q.size() <= DEPTH - 4) m_rts = 1'b0;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
        upd_rts();
    endfunction

    function automatic logic [31:0] model_pop();
        logic [7:0] b;
        if (q.size() == 0) return 32'h0;
        b = q.pop_front();
        upd_rts();
        return {1'b1, 23'b0, b};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [4:0] c;
        c = 5'(q.size());
        return {16'b0, 3'b0, c, 5'b0, m_perr, m_ferr, m_ovr};
    endfunction

    task automatic bus_access(input logic [3:0] off, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] rdata);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE | {28'b0, off};
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        #1 check("rx_sel", {31'b0, bus.rx_sel}, 32'h1);
        @(negedge clk);
        check("ack", {31'b0, bus.rx_ready}, 32'h1);
        rdata = bus.rx_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(negedge clk);
        check("ack_drop", bus.rx_rdata | {31'b0, bus.rx_ready}, 32'h0);
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] r;
        bus_access(off, 32'h0, 4'h0, r);
        check(nm, r, exp);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] wdata);
        logic [31:0] r;
        bus_access(off, wdata, 4'hF, r);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        ser_rx = par_ok ? ^d : ~^d;
        repeat (DIV) @(negedge clk);
`else
        if (!par_ok) $display("note: parity ignored in 8N1 build");
`endif
        ser_rx = stop;
        repeat (DIV) @(negedge clk);
        ser_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    vec_t vecs[13];
    logic [31:0] r, e;

    initial begin
        vecs[0]  = '{4'hC, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[1]  = '{4'hC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[2]  = '{4'h8, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[3]  = '{4'h4, 32'h0,        4'h0, 1'b1, 32'h0000_0102};
        vecs[4]  = '{4'h0, 32'hFF,       4'h1, 1'b0, 32'h0};
        vecs[5]  = '{4'h4, 32'h0,        4'h0, 1'b1, 32'h0000_0102};
        vecs[6]  = '{4'h4, 32'h1,        4'hF, 1'b0, 32'h0};
        vecs[7]  = '{4'h4, 32'h0,        4'h0, 1'b1, 32'h0000_0102};
        vecs[8]  = '{4'h4, 32'h2,        4'hF, 1'b0, 32'h0};
        vecs[9]  = '{4'h4, 32'h0,        4'h0, 1'b1, 32'h0000_0100};
        vecs[10] = '{4'h0, 32'h0,        4'h0, 1'b1, 32'h8000_00A5};
        vecs[11] = '{4'h0, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[12] = '{4'h4, 32'h0,        4'h0, 1'b1, 32'h0};

        rst = 1'b1;
        ser_rx = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.rx_ready}, 32'h0);
        check("rst_rdata", bus.rx_rdata, 32'h0);
        check("rst_rts", {31'b0, ser_rts}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A5 good frame, then a framing-error frame; register map table
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            bus_access(vecs[i].off, vecs[i].wdata, vecs[i].wstrb, r);
            if (vecs[i].chk) check($sformatf("vec[%0d]", i), r, vecs[i].exp);
        end

        // out-of-window request: no select, no ack
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h10;
        #1 check("oow_sel", {31'b0, bus.rx_sel}, 32'h0);
        repeat (3) @(negedge clk);
        check("oow_ready", {31'b0, bus.rx_ready}, 32'h0);
        bus.mem_valid = 1'b0;

        // mem_valid held after the ack: exactly one pulse
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'hC;
        @(negedge clk);
        check("hold_ack", {31'b0, bus.rx_ready}, 32'h1);
        @(negedge clk);
        check("hold_low1", bus.rx_rdata | {31'b0, bus.rx_ready}, 32'h0);
        @(negedge clk);
        check("hold_low2", {31'b0, bus.rx_ready}, 32'h0);
        bus.mem_valid = 1'b0;
        repeat (2) @(negedge clk);

        // burst of 17 with no reads
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            model_push(8'(i));
            check($sformatf("rts_fill%0d", i), {31'b0, ser_rts}, {31'b0, m_rts});
        end
        rd(4'h4, 32'h0000_1001, "burst_status");
        for (int i = 0; i < 16; i++) begin
            e = model_pop();
            rd(4'h0, e, $sformatf("burst_rd%0d", i));
            check($sformatf("rts_drain%0d", i), {31'b0, ser_rts}, {31'b0, m_rts});
        end
        wr(4'h4, 32'h1);
        m_ovr = 1'b0;
        rd(4'h4, exp_status(), "ovr_clear");

        // 3-clock glitch
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (3) @(negedge clk);
        ser_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(4'h4, 32'h0, "glitch_status");
        send_frame(8'hC3, 1'b1, 1'b1);
        rd(4'h0, 32'h8000_00C3, "after_glitch");

        // framing error and clear
        send_frame(8'h81, 1'b0, 1'b1);
        m_ferr = 1'b1;
        rd(4'h4, 32'h0000_0002, "ferr_status");
        wr(4'h4, 32'h2);
        m_ferr = 1'b0;
        rd(4'h4, 32'h0, "ferr_clear");

        // full FIFO: pop ack in the same cycle as a push
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1, 1'b1);
            model_push(8'h20 + 8'(i));
        end
        fork
            send_frame(8'h77, 1'b1, 1'b1);
            begin
                @(negedge clk);
                repeat (PUSH_EDGE - 1) @(posedge clk);
                bus_access(4'h0, 32'h0, 4'h0, r);
            end
        join
        e = model_pop();
        model_push(8'h77);
        check("coincide_rd", r, e);
        rd(4'h4, 32'h0000_1000, "coincide_status");
        check("rts_full", {31'b0, ser_rts}, {31'b0, m_rts});

        // reset mid-DATA after 3 bits
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser_rx = 1'(8'h5A >> i);
            repeat (DIV) @(negedge clk);
        end
        ser_rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", {31'b0, bus.rx_ready}, 32'h0);
        check("midrst_rdata", bus.rx_rdata, 32'h0);
        check("midrst_rts", {31'b0, ser_rts}, 32'h0);
        rst = 1'b0;
        q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_rts = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        rd(4'h4, 32'h0000_0100, "midrst_status");
        rd(4'h0, 32'h8000_003C, "midrst_data");
        rd(4'h0, 32'h0, "midrst_empty");
`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b0);
        m_perr = 1'b1;
        rd(4'h4, 32'h0000_0004, "perr_status");
        wr(4'h4, 32'h4);
        m_perr = 1'b0;
        rd(4'h4, 32'h0, "perr_clear");
`endif

        // randomized traffic against the queue model
        for (int it = 0; it < 40; it++) begin
            int unsigned sel;
            logic [7:0] b;
            logic [2:0] w;
            sel = $urandom_range(0, 99);
            b = 8'($urandom);
            if (sel < 45) begin
                send_frame(b, 1'b1, 1'b1);
                model_push(b);
            end else if (sel < 50) begin
                send_frame(b, 1'b0, 1'b1);
                m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (sel < 54) begin
                send_frame(b, 1'b1, 1'b0);
                m_perr = 1'b1;
`endif
            end else if (sel < 80) begin
                e = model_pop();
                rd(4'h0, e, "rand_data");
            end else if (sel < 93) begin
                rd(4'h4, exp_status(), "rand_status");
                w = 3'($urandom_range(0, 7));
                wr(4'h4, {29'b0, w});
                if (w[0]) m_ovr = 1'b0;
                if (w[1]) m_ferr = 1'b0;
                if (w[2]) m_perr = 1'b0;
            end else begin
                wr(4'h8, 32'h1);
                q.delete();
                upd_rts();
            end
            repeat (2) @(negedge clk);
            check("rand_rts", {31'b0, ser_rts}, {31'b0, m_rts});
        end
        rd(4'h4, exp_status(), "final_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
